spi_target_regfile: RTL and testbench

SPI mode-0 target with a small byte-wide register file. It sits directly downstream of the SoC's SPI0 controller pins (sclk/ss/mosi in, miso out) and gives firmware a loopback-capable peripheral for bring-up and bench verification. All SPI inputs are oversampled and synchronised into the `io_clock` domain. The register contents are exported as a flat vector with a one-cycle write strobe.

---
 rtl/spi_target_pkg.sv | 15 +
 rtl/spi_target_sync.sv | 41 ++++
 rtl/spi_target_regfile.sv | 156 +++++++++++++++
 tb/tb_spi_target_regfile.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI target register file
package spi_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int CMD_RD_BIT = 7;
    localparam int ADDR_W     = 7;
    localparam int CNT_W      = $clog2(BYTE_W);

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - multi-stage input synchroniser with registered rise/fall detect
module spi_target_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [STAGES-1:0][W-1:0] r_sync;
    logic [W-1:0]             r_prev;
    logic [W-1:0]             r_rise;
    logic [W-1:0]             r_fall;
    logic [W-1:0]             w_last;

    assign w_last = r_sync[STAGES-1];

    // Chain resets low so a select held low through reset never looks like a fresh falling edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= w_last;
            r_rise <= w_last & ~r_prev;
            r_fall <= ~w_last & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_target_regfile.sv
// rtl/spi_target_regfile.sv - SPI mode-0 target with byte register file; SPI_TARGET_BURST_EN enables auto-increment bursts
module spi_target_regfile
    import spi_target_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  io_clock,
    input  logic                  io_reset,
    input  logic                  io_spi_sclk,
    input  logic                  io_spi_ss,
    input  logic                  io_spi_mosi,
    output logic                  io_spi_miso,
    output logic [DEPTH*8-1:0]    io_regs,
    output logic                  io_wrStrobe,
    output logic [ADDR_W-1:0]     io_wrAddr,
    output logic                  io_frameError
);

`ifdef SPI_TARGET_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    logic [2:0] w_level, w_rise, w_fall;
    logic       w_unused;

    spi_target_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (io_clock),
        .i_rst   (io_reset),
        .i_d     ({io_spi_mosi, io_spi_ss, io_spi_sclk}),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
    assign w_sclk_rise = w_rise[0];
    assign w_sclk_fall = w_fall[0];
    assign w_ss_rise   = w_rise[1];
    assign w_ss_fall   = w_fall[1];
    assign w_mosi      = w_level[2];
    assign w_unused    = ^{w_level[1:0], w_rise[2], w_fall[2]};

    state_t             r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [BYTE_W-1:0]  r_rx;
    logic [BYTE_W-1:0]  r_tx;
    logic               r_is_read;
    logic               r_first;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_miso;
    logic               r_wr_strobe;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_frame_err;
    logic [BYTE_W-1:0]  r_regs [DEPTH];

    logic [BYTE_W-1:0]  w_byte;
    logic               w_last_bit;
    logic [ADDR_W-1:0]  w_next_addr;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [BYTE_W-1:0]  w_rd_data;

    assign w_byte      = {r_rx[BYTE_W-2:0], w_mosi};
    assign w_last_bit  = (r_bit_cnt == CNT_W'(BYTE_W - 1));
    assign w_next_addr = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
    // Command byte reads the addressed register; later burst bytes read the next one
    assign w_rd_addr   = (r_state == ST_CMD) ? w_byte[ADDR_W-1:0] : w_next_addr;
    assign w_rd_data   = in_range(w_rd_addr) ? r_regs[w_rd_addr[IDX_W-1:0]] : '0;

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_is_read   <= 1'b0;
            r_first     <= 1'b0;
            r_addr      <= '0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_ss_rise) begin
                if (r_state != ST_IDLE && r_bit_cnt != '0) r_frame_err <= 1'b1;
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= '0;
                            r_rx      <= '0;
                            r_tx      <= '0;
                        end
                    end
                    ST_CMD, ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_byte;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            if (w_last_bit) begin
                                if (r_state == ST_CMD) begin
                                    r_state   <= ST_DATA;
                                    r_is_read <= w_byte[CMD_RD_BIT];
                                    r_addr    <= w_byte[ADDR_W-1:0];
                                    r_first   <= 1'b1;
                                    r_tx      <= w_byte[CMD_RD_BIT] ? w_rd_data : '0;
                                end else begin
                                    r_first <= 1'b0;
                                    if (!r_is_read && (BURST || r_first) && in_range(r_addr)) begin
                                        r_regs[r_addr[IDX_W-1:0]] <= w_byte;
                                        r_wr_strobe <= 1'b1;
                                        r_wr_addr   <= r_addr;
                                    end
                                    if (BURST) begin
                                        r_addr <= w_next_addr;
                                        if (r_is_read) r_tx <= w_rd_data;
                                    end
                                end
                            end
                        end else if (w_sclk_fall) begin
                            r_miso <= r_tx[BYTE_W-1];
                            r_tx   <= {r_tx[BYTE_W-2:0], 1'b0};
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_export
        assign io_regs[g*8 +: 8] = r_regs[g];
    end

    assign io_spi_miso   = r_miso & ~io_spi_ss;
    assign io_wrStrobe   = r_wr_strobe;
    assign io_wrAddr     = r_wr_addr;
    assign io_frameError = r_frame_err;

endmodule

// File: tb/tb_spi_target_regfile.sv
// tb/tb_spi_target_regfile.sv - randomized self-checking bench for spi_target_regfile
module tb_spi_target_regfile;

    localparam int DEPTH = 16;
`ifdef SPI_TARGET_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sclk, ss, mosi;
    logic                 miso;
    logic [DEPTH*8-1:0]   regs;
    logic                 wr_strobe;
    logic [6:0]           wr_addr;
    logic                 ferr;

    always #5 clk = ~clk;

    spi_target_regfile #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .io_clock      (clk),
        .io_reset      (rst),
        .io_spi_sclk   (sclk),
        .io_spi_ss     (ss),
        .io_spi_mosi   (mosi),
        .io_spi_miso   (miso),
        .io_regs       (regs),
        .io_wrStrobe   (wr_strobe),
        .io_wrAddr     (wr_addr),
        .io_frameError (ferr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference register contents
    logic [7:0] m_regs [DEPTH];

    function automatic logic [DEPTH*8-1:0] m_flat();
        logic [DEPTH*8-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i*8 +: 8] = m_regs[i];
        return v;
    endfunction

    // Observed strobes and frame errors
    logic [6:0] obs_addr [$];
    logic [7:0] obs_data [$];
    int         obs_ferr = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) begin
                obs_addr.push_back(wr_addr);
                obs_data.push_back((int'(wr_addr) < DEPTH) ? regs[int'(wr_addr)*8 +: 8] : 8'hxx);
            end
            if (ferr) obs_ferr++;
        end
    end

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = b[i];
            half();
            r[i] = miso;
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input int nbytes, input int tail_bits);
        ss = 1'b0;
        half();
        for (int k = 0; k < nbytes; k++) xfer_bits(tx_buf[k], 8, rx_buf[k]);
        if (tail_bits > 0) xfer_bits(tx_buf[nbytes], tail_bits, rx_buf[nbytes]);
        half();
        ss = 1'b1;
        half();
        half();
    endtask

    task automatic run_checked(input string tag, input int nbytes);
        logic [7:0] exp_rx [8];
        logic [6:0] exp_addr [$];
        logic [7:0] exp_data [$];
        logic       rd, active, hit;
        logic [6:0] a;
        int         s0, f0, n_obs;
        s0 = obs_addr.size();
        f0 = obs_ferr;
        frame(nbytes, 0);
        rd = tx_buf[0][7];
        a  = tx_buf[0][6:0];
        exp_rx[0] = 8'h00;
        for (int k = 1; k < nbytes; k++) begin
            active = BURST || (k == 1);
            hit    = active && (int'(a) < DEPTH);
            exp_rx[k] = 8'h00;
            if (rd) begin
                if (hit) exp_rx[k] = m_regs[int'(a)];
            end else if (hit) begin
                m_regs[int'(a)] = tx_buf[k];
                exp_addr.push_back(a);
                exp_data.push_back(tx_buf[k]);
            end
            if (BURST) a = (int'(a) == DEPTH - 1) ? 7'd0 : a + 7'd1;
        end
        for (int k = 0; k < nbytes; k++)
            chk($sformatf("%s rx%0d", tag, k), rx_buf[k], exp_rx[k]);
        n_obs = obs_addr.size() - s0;
        chk($sformatf("%s nstrobe", tag), n_obs, exp_addr.size());
        for (int i = 0; i < n_obs && i < exp_addr.size(); i++) begin
            chk($sformatf("%s waddr%0d", tag, i), obs_addr[s0+i], exp_addr[i]);
            chk($sformatf("%s wdata%0d", tag, i), obs_data[s0+i], exp_data[i]);
        end
        chk($sformatf("%s regs", tag), regs, m_flat());
        chk($sformatf("%s ferr", tag), obs_ferr - f0, 0);
    endtask

    logic [7:0] dummy, old0;
    int         s0, f0;

    initial begin
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
        repeat (4) @(negedge clk);
        chk("reset regs", regs, '0);
        chk("reset miso", miso, 1'b0);
        chk("reset strobe", wr_strobe, 1'b0);
        chk("reset waddr", wr_addr, 7'd0);
        chk("reset ferr", ferr, 1'b0);
        rst = 1'b0;
        half();

        tx_buf[0] = 8'h03; tx_buf[1] = 8'hA5;
        run_checked("wr3", 2);
        chk("wr3 reg3", regs[31:24], 8'hA5);

        tx_buf[0] = 8'h83; tx_buf[1] = 8'h00;
        run_checked("rd3", 2);
        chk("rd3 cmd miso", rx_buf[0], 8'h00);
        chk("rd3 data", rx_buf[1], 8'hA5);

        tx_buf[0] = 8'h14; tx_buf[1] = 8'h77;
        run_checked("wr_oor", 2);

        tx_buf[0] = 8'h94; tx_buf[1] = 8'h5A;
        run_checked("rd_oor", 2);
        chk("rd_oor data", rx_buf[1], 8'h00);

        // Abort after 5 data bits
        s0 = obs_addr.size(); f0 = obs_ferr;
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h3C;
        frame(1, 5);
        chk("abort ferr", obs_ferr - f0, 1);
        chk("abort nstrobe", obs_addr.size() - s0, 0);
        chk("abort regs", regs, m_flat());
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h5A;
        run_checked("after_abort", 2);

        old0 = m_regs[0];
        s0 = obs_addr.size();
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        run_checked("burst", 3);
        chk("burst reg15", regs[127:120], 8'h11);
        chk("burst reg0", regs[7:0], BURST ? 8'h22 : old0);
        chk("burst strobes", obs_addr.size() - s0, BURST ? 2 : 1);

        tx_buf[0] = 8'h8F; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        run_checked("burst_rd", 3);

        for (int t = 0; t < 25; t++) begin
            int nb;
            nb = $urandom_range(2, 4);
            tx_buf[0] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
            for (int k = 1; k < 8; k++) tx_buf[k] = 8'($urandom);
            run_checked($sformatf("rnd%0d", t), nb);
        end

        // Reset during the command byte of a write
        s0 = obs_addr.size(); f0 = obs_ferr;
        ss = 1'b0;
        half();
        xfer_bits(8'h05, 4, dummy);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst regs", regs, '0);
        chk("midrst miso", miso, 1'b0);
        chk("midrst strobe", wr_strobe, 1'b0);
        chk("midrst waddr", wr_addr, 7'd0);
        chk("midrst ferr", ferr, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
        xfer_bits(8'h50, 4, dummy);
        xfer_bits(8'hEE, 8, dummy);
        half();
        ss = 1'b1;
        half();
        half();
        chk("midrst nstrobe", obs_addr.size() - s0, 0);
        chk("midrst nferr", obs_ferr - f0, 0);
        chk("midrst regs after", regs, '0);

        tx_buf[0] = 8'h07; tx_buf[1] = 8'h42;
        run_checked("post_rst", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
